// File: rtl/uart_hex_loader_pkg.sv
// Shared types, ASCII constants and character-decode helpers for the hex loader.
package uart_hex_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_SKIP = 3'd3,
    ST_EMIT = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_AT  = 8'h40;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  // A token holds at most one 32-bit word of hex digits.
  localparam logic [3:0] MAX_DIGITS = 4'd8;

  // Returns {is_hex, nibble}; nibble is zero for non-hex characters.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      r = {1'b1, c[3:0]};
    end else if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

  function automatic logic is_space(input logic [7:0] c);
    return (c == ASCII_SP) || (c == ASCII_TAB) || (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_hex_char_classify.sv
// Combinational ASCII classifier: splits a received byte into the token classes the parser needs.
module uart_hex_char_classify
  import uart_hex_loader_pkg::*;
(
  input  logic [7:0] char_code,
  output logic       hex_digit,
  output logic       space_char,
  output logic       at_char,
  output logic [3:0] nibble
);

  logic [4:0] decode_s;

  // Decode the byte into class flags and its hex value.
  always_comb begin
    decode_s   = ascii_to_nibble(char_code);
    hex_digit  = decode_s[4];
    nibble     = decode_s[3:0];
    space_char = is_space(char_code);
    at_char    = (char_code == ASCII_AT);
  end

endmodule

// File: rtl/uart_hex_loader.sv
// Parses a whitespace-separated ASCII hex stream ("@addr" and data words) from the
// UART receiver into 32-bit memory write requests with auto-incrementing address.
module uart_hex_loader
  import uart_hex_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_INIT = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        format_error,
  output logic        overflow
);

  state_t      state_r;
  logic [31:0] acc_r;
  logic [3:0]  cnt_r;
  logic [31:0] address_r;
  logic        wr_valid_r;
  logic [31:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic        format_error_r;
  logic        overflow_r;

  logic        hex_s;
  logic        space_s;
  logic        at_s;
  logic [3:0]  nibble_s;
  state_t      idle_next_s;

  uart_hex_char_classify u_classify (
    .char_code  (byte_data),
    .hex_digit  (hex_s),
    .space_char (space_s),
    .at_char    (at_s),
    .nibble     (nibble_s)
  );

  // Next state for a byte seen at token start (IDLE, or EMIT in its handshake cycle).
  always_comb begin
    idle_next_s = ST_SKIP;
    if (hex_s) begin
      idle_next_s = ST_DATA;
    end else if (at_s) begin
      idle_next_s = ST_ADDR;
    end else if (space_s) begin
      idle_next_s = ST_IDLE;
    end else begin
      idle_next_s = ST_SKIP;
    end
  end

  // Parser FSM: token accumulation, address tracking, write handshake and sticky flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      acc_r          <= 32'd0;
      cnt_r          <= 4'd0;
      address_r      <= ADDR_INIT;
      wr_valid_r     <= 1'b0;
      wr_addr_r      <= ADDR_INIT;
      wr_data_r      <= 32'd0;
      format_error_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (byte_ready) begin
            state_r <= idle_next_s;
            // '@' clears the accumulator (nibble is 0 then); a digit seeds it
            acc_r   <= {28'd0, nibble_s};
            cnt_r   <= hex_s ? 4'd1 : 4'd0;
            if (idle_next_s == ST_SKIP) begin
              format_error_r <= 1'b1;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (byte_ready) begin
            if (hex_s && (cnt_r < MAX_DIGITS)) begin
              acc_r <= {acc_r[27:0], nibble_s};
              cnt_r <= cnt_r + 4'd1;
            end else if (space_s) begin
              if (state_r == ST_ADDR) begin
                // An empty "@" token leaves the address alone
                if (cnt_r != 4'd0) begin
                  address_r <= {acc_r[31:2], 2'b00};
                end
                state_r <= ST_IDLE;
              end else begin
                wr_data_r  <= acc_r;
                wr_addr_r  <= address_r;
                wr_valid_r <= 1'b1;
                state_r    <= ST_EMIT;
              end
            end else begin
              // Ninth digit, stray '@' or illegal character: drop the whole token
              format_error_r <= 1'b1;
              state_r        <= ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (byte_ready && space_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (wr_ready) begin
            wr_valid_r <= 1'b0;
            address_r  <= address_r + ADDR_STEP;
            state_r    <= ST_IDLE;
            // A byte landing on the handshake cycle starts the next token immediately
            if (byte_ready) begin
              state_r <= idle_next_s;
              acc_r   <= {28'd0, nibble_s};
              cnt_r   <= hex_s ? 4'd1 : 4'd0;
              if (idle_next_s == ST_SKIP) begin
                format_error_r <= 1'b1;
              end
            end
          end else if (byte_ready) begin
            overflow_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          wr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid     = wr_valid_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign busy         = (state_r != ST_IDLE);
  assign format_error = format_error_r;
  assign overflow     = overflow_r;

endmodule

// File: doc/uart_hex_loader.md
# uart_hex_loader

Downstream consumer of the UART byte receiver. It accepts one received ASCII byte per `byte_ready` pulse and parses a whitespace-separated hex stream. `@AAAAAAAA` tokens set the load address; `DDDDDDDD` tokens become 32-bit memory write requests on a valid/ready port, with auto-increment of the address. It feeds the program/data memory loader path.

## Interface
- `ADDR_INIT`, 32'h0000_0000, write address after reset.
- `ADDR_STEP`, 4, byte increment applied after each accepted write.
- `clock`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `byte_data`  in  8  received ASCII byte; valid only while `byte_ready`=1.
- `byte_ready`  in  1  one-cycle strobe from the receiver; no backpressure possible.
- `wr_valid`  out  1  write request pending.
- `wr_ready`  in  1  memory side accepts the request.
- `wr_addr`  out  32  write address, stable while `wr_valid`.
- `wr_data`  out  32  write data, stable while `wr_valid`.
- `busy`  out  1  state != IDLE.
- `format_error`  out  1  sticky; illegal character or token over 8 digits.
- `overflow`  out  1  sticky; byte arrived while a write was stalled and was dropped.

## Operation
- Character classes:
  - hex digit: `0-9`, `a-f`, `A-F`.
  - whitespace: 0x20, 0x09, 0x0D, 0x0A.
  - `@`: 0x40.
  - anything else: illegal.
- States: IDLE, ADDR, DATA, SKIP, EMIT.
- IDLE:
  - `@` -> ADDR, accumulator=0, digit count=0.
  - hex digit -> DATA, accumulator=digit, count=1.
  - whitespace -> stay.
  - illegal -> set `format_error`, go SKIP.
- ADDR/DATA:
  - hex digit with count<8 -> accumulator = {accumulator[27:0], nibble}, count+1.
  - 9th digit, `@` or illegal char -> set `format_error`, discard token, go SKIP.
- ADDR + whitespace:
  - count>0 -> address = accumulator with bits [1:0] cleared.
  - count=0 -> address unchanged.
  - next state IDLE.
- DATA + whitespace -> `wr_data` = accumulator (fewer than 8 digits zero-extend), `wr_addr` = address, go EMIT.
- SKIP: whitespace -> IDLE; all other bytes ignored.
- EMIT:
  - `wr_valid`=1; on `wr_valid && wr_ready`, address += `ADDR_STEP` (mod 2^32), go IDLE.
  - `byte_ready` while `wr_ready`=0 -> byte dropped, `overflow` set.
  - `byte_ready` in the handshake cycle -> byte processed exactly as in IDLE, same cycle.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - state IDLE; address = `ADDR_INIT`.
  - `wr_valid`=0, `wr_addr`=`ADDR_INIT`, `wr_data`=0.
  - `busy`=0, `format_error`=0, `overflow`=0.
- Every byte is consumed in its `byte_ready` cycle; all state and outputs update at the next clock edge.
- Terminating whitespace at edge N -> `wr_valid`=1 from cycle N+1.
- Zero-wait memory (`wr_ready`=1): `wr_valid` high exactly 1 cycle; address increment is visible the cycle after the handshake.
- Minimum byte spacing at 9600 baud is thousands of cycles, so overflow occurs only under sustained `wr_ready`=0.
- Address wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000, no flag.
- Flags assert one cycle after the offending byte.
- Reset mid-token or mid-EMIT aborts the token; no write issued.

## Structure
- Package `uart_hex_loader_pkg`:
  - state enum.
  - ASCII constants (`@`, SP, TAB, CR, LF).
  - function `ascii_to_nibble` returning {is_hex, nibble[3:0]}.
  - function `is_space`.
- Sub-module `uart_hex_char_classify` (combinational): byte -> {is_hex, is_space, is_at, nibble}; keeps the FSM module free of decode logic.

## Test plan
- Reset, then send `"@00000100 DEADBEEF 12\n"` with `wr_ready`=1 -> writes (0x100, 0xDEADBEEF) then (0x104, 0x00000012); flags 0.
- Send `"CAFEF00D "` with `wr_ready` held 0 for 50 cycles -> `wr_valid` held, addr/data stable; handshake on release; next write addr +4.
- Send `"123456789 55 "` -> `format_error`=1 after the 9th digit; only write is 0x00000055 at `ADDR_INIT`.
- Send `"@FFFFFFFC 1 2 "` -> writes at 0xFFFFFFFC then 0x00000000.
- `wr_ready`=0, send `"AA BB "` -> one pending write (0xAA); bytes `B`,`B`,SP dropped; `overflow`=1.
- Assert `reset_n`=0 after `"@0000"` -> outputs at reset values; following `"77 "` writes 0x77 at `ADDR_INIT`.
